// File: rtl/ahb_lite_master_bridge_pkg.sv
// Shared AHB-Lite encodings, bridge FSM states and the command legality rule.
package ahb_lite_master_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR2 = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // Only byte/half/word sizes exist on this 32-bit bus, and each must be naturally aligned.
  function automatic logic cmd_is_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lsb[0];
      HSIZE_WORD: ok = (addr_lsb == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_lite_master_bridge_wait_timer.sv
// Loadable down-counter for data-phase wait states; o_expired pulses on the final counted cycle.
module ahb_lite_master_bridge_wait_timer #(
  parameter int LOAD_VALUE = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  localparam int W = $clog2(LOAD_VALUE + 1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(LOAD_VALUE);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = i_dec && (r_count == W'(1));

endmodule

// File: rtl/ahb_lite_master_bridge.sv
// Single-outstanding AHB-Lite master: one command in, one SINGLE transfer out, one response back.
// Define AHB_MASTER_TIMEOUT_EN to abort data phases that stall for TIMEOUT_CYCLES cycles.
module ahb_lite_master_bridge
  import ahb_lite_master_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [3:0] HPROT_VALUE    = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [2:0]  o_dbg_state
);

  // Both streams are valid/ready: a beat transfers on the rising edge where valid and ready are
  // both high; the producer holds valid and payload stable until then.

  state_t      r_state;
  state_t      w_next;
  logic        r_out_of_reset;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_legal;
  logic        w_capture_cmd;
  logic        w_capture_rsp;
  logic        w_rsp_err_nx;
  logic [31:0] w_rsp_rdata_nx;
  logic        w_timeout;

  assign w_legal = cmd_is_legal(cmd_size, cmd_addr[1:0]);

`ifdef AHB_MASTER_TIMEOUT_EN
  logic w_timer_load;
  logic w_wait_tick;

  assign w_timer_load = w_capture_cmd && w_legal;
  assign w_wait_tick  = ((r_state == ST_DATA) || (r_state == ST_ERR2)) && !HREADY;

  ahb_lite_master_bridge_wait_timer #(
    .LOAD_VALUE (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk     (HCLK),
    .i_rst     (HRESET),
    .i_load    (w_timer_load),
    .i_dec     (w_wait_tick),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state        <= ST_IDLE;
      r_out_of_reset <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_out_of_reset <= 1'b1;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_capture_cmd  = 1'b0;
    w_capture_rsp  = 1'b0;
    w_rsp_err_nx   = 1'b0;
    w_rsp_rdata_nx = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_out_of_reset) begin
          w_capture_cmd = 1'b1;
          if (w_legal) begin
            w_next = ST_ADDR;
          end else begin
            w_next        = ST_RESP;
            w_capture_rsp = 1'b1;
            w_rsp_err_nx  = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (HREADY) w_next = ST_DATA;
      end
      ST_DATA: begin
        if (HREADY) begin
          // An ERROR that arrives without the first wait cycle is still an error completion.
          w_next         = ST_RESP;
          w_capture_rsp  = 1'b1;
          w_rsp_err_nx   = HRESP;
          w_rsp_rdata_nx = (!r_write && !HRESP) ? HRDATA : 32'h0;
        end else if (w_timeout) begin
          w_next        = ST_RESP;
          w_capture_rsp = 1'b1;
          w_rsp_err_nx  = 1'b1;
        end else if (HRESP) begin
          w_next = ST_ERR2;
        end
      end
      ST_ERR2: begin
        if (HREADY || w_timeout) begin
          w_next        = ST_RESP;
          w_capture_rsp = 1'b1;
          w_rsp_err_nx  = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_addr      <= 32'h0;
      r_size      <= HSIZE_BYTE;
      r_write     <= 1'b0;
      r_wdata     <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_capture_cmd) begin
        r_addr  <= cmd_addr;
        r_size  <= cmd_size;
        r_write <= cmd_write;
        r_wdata <= cmd_wdata;
      end
      if (w_capture_rsp) begin
        r_rsp_rdata <= w_rsp_rdata_nx;
        r_rsp_err   <= w_rsp_err_nx;
      end
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE) && r_out_of_reset;
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;

  assign HTRANS      = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR       = r_addr;
  assign HSIZE       = r_size;
  assign HWRITE      = r_write;
  assign HWDATA      = ((r_state == ST_DATA) && r_write) ? r_wdata : 32'h0;
  assign HBURST      = HBURST_SINGLE;
  assign HMASTLOCK   = 1'b0;
  assign HPROT       = HPROT_VALUE;
  assign o_dbg_state = r_state;

endmodule
